display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 13 +
 rtl/display_scan_mux.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and the BCD-to-7-segment mapping for the display scan multiplexer.
// All segment patterns are active-low: bits [6:0] = a..g, bit 7 = dp.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG7_OFF  = 7'h7F;

  localparam logic [6:0] SEG7_D0 = 7'h40;
  localparam logic [6:0] SEG7_D1 = 7'h79;
  localparam logic [6:0] SEG7_D2 = 7'h24;
  localparam logic [6:0] SEG7_D3 = 7'h30;
  localparam logic [6:0] SEG7_D4 = 7'h19;
  localparam logic [6:0] SEG7_D5 = 7'h12;
  localparam logic [6:0] SEG7_D6 = 7'h02;
  localparam logic [6:0] SEG7_D7 = 7'h78;
  localparam logic [6:0] SEG7_D8 = 7'h00;
  localparam logic [6:0] SEG7_D9 = 7'h10;

  // Non-BCD codes (10..15) show nothing rather than hex glyphs.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = SEG7_D0;
      4'd1:    pattern = SEG7_D1;
      4'd2:    pattern = SEG7_D2;
      4'd3:    pattern = SEG7_D3;
      4'd4:    pattern = SEG7_D4;
      4'd5:    pattern = SEG7_D5;
      4'd6:    pattern = SEG7_D6;
      4'd7:    pattern = SEG7_D7;
      4'd8:    pattern = SEG7_D8;
      4'd9:    pattern = SEG7_D9;
      default: pattern = SEG7_OFF;
    endcase
    return pattern;
  endfunction

  // Scan index needs at least one bit even for a single-digit display.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational BCD digit to active-low a..g segment pattern.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = bcd_to_seg(code);
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment driver: per-frame latched source, blink gating,
// optional leading-zero blanking, registered active-low seg/an outputs.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] time_digits,
  input  logic [4*NUM_DIGITS-1:0] alarm_digits,
  input  logic                    alarm_sel,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] frame_dig_q, frame_dig_d;
  logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    scan_tick;
  logic                    frame_wrap;
  logic                    blk_tick;
  logic                    blank_all;
  logic [NUM_DIGITS-1:0]   idx_onehot;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [6:0]              cur_seg7;

  assign scan_tick  = (ref_cnt_q == REF_LAST);
  assign frame_wrap = scan_tick && (idx_q == IDX_LAST);
  assign blk_tick   = (blk_cnt_q == BLK_LAST);
  assign blank_all  = blink_en && !blink_phase_q;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign idx_onehot[gi] = (idx_q == IDX_W'(gi));
  end

  // lz_mask[k]: digit k and every latched digit above it are zero; digit 0 is exempt.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (frame_dig_q[4*k +: 4] == 4'd0);
      if (k != 0) begin
        lz_mask[k] = LZ_BLANK && upper_zero;
      end
    end
  end

  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_onehot[k]) begin
        cur_code = frame_dig_q[4*k +: 4];
        cur_dp   = frame_dp_q[k];
        cur_lz   = lz_mask[k];
      end
    end
  end

  seg7_decode u_decode (
    .code  (cur_code),
    .seg_n (cur_seg7)
  );

  always_comb begin
    ref_cnt_d     = scan_tick ? '0 : ref_cnt_q + REF_W'(1);
    blk_cnt_d     = blk_tick ? '0 : blk_cnt_q + BLK_W'(1);
    blink_phase_d = blk_tick ? !blink_phase_q : blink_phase_q;

    idx_d = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // The whole frame is sourced at once so a display never mixes time and alarm.
    frame_dig_d = frame_dig_q;
    frame_dp_d  = frame_dp_q;
    if (frame_wrap) begin
      frame_dig_d = alarm_sel ? alarm_digits : time_digits;
      frame_dp_d  = dp_mask;
    end

    an_d  = '1;
    seg_d = SEG_BLANK;
    if (!blank_all) begin
      an_d  = ~idx_onehot;
      seg_d = cur_lz ? SEG_BLANK : {~cur_dp, cur_seg7};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q     <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b1;
      idx_q         <= '0;
      frame_dig_q   <= '0;
      frame_dp_q    <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      frame_dig_q   <= frame_dig_d;
      frame_dp_q    <= frame_dp_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
